// File: rtl/fft_consts_pkg.sv
// Shared FFT constants and the address-generator state encoding.
package fft_consts;
  localparam int N_LOG2     = 10;
  localparam int BFU_LAT    = 5;
  localparam int RAM_RD_LAT = 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} agu_state_t;
endpackage

// File: rtl/fft_delay_line.sv
// Fixed-depth register shift chain; async reset flushes every stage.
module fft_delay_line #(
  parameter int DEPTH = 6,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [DEPTH-1:0][WIDTH-1:0] pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];
endmodule

// File: rtl/fft_agu.sv
// In-place radix-2 FFT address generator: one butterfly per RUN cycle,
// ping-pong banks per stage, write side delayed to match RAM + BFU latency.
module fft_agu #(
  parameter int N_LOG2  = fft_consts::N_LOG2,
  parameter int RD_LAT  = fft_consts::RAM_RD_LAT,
  parameter int BFU_LAT = fft_consts::BFU_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [N_LOG2-1:0] stage,
  output logic [N_LOG2-1:0] rd_addrA,
  output logic [N_LOG2-1:0] rd_addrB,
  output logic [N_LOG2-2:0] twiddle_idx,
  output logic              in_valid,
  output logic              bank_sel,
  output logic [N_LOG2-1:0] wr_addrA,
  output logic [N_LOG2-1:0] wr_addrB,
  output logic              wr_en,
  output logic              wr_bank_sel
);
  import fft_consts::*;

  localparam int KW     = N_LOG2 - 1;
  localparam int HALF_N = 1 << KW;
  localparam int DLY    = RD_LAT + BFU_LAT;
  localparam int CW     = (DLY > 1) ? $clog2(DLY) : 1;
  localparam int WW     = 2 * N_LOG2 + 2;

  agu_state_t        state, state_n;
  logic [KW-1:0]     k, k_n;
  logic [N_LOG2-1:0] stage_n;
  logic              bank_n;
  logic [CW-1:0]     dcnt, dcnt_n;

  logic [N_LOG2-1:0] kx, half, mask, a_n, b_n;
  logic [KW-1:0]     tw_n;

  always_comb begin
    state_n = state;
    k_n     = k;
    stage_n = stage;
    bank_n  = bank_sel;
    dcnt_n  = dcnt;
    case (state)
      IDLE: if (start) begin
        state_n = RUN;
        k_n     = '0;
        stage_n = '0;
        bank_n  = 1'b0;
      end
      RUN: begin
        if (k == KW'(HALF_N - 1)) begin
          state_n = DRAIN;
          dcnt_n  = '0;
        end else begin
          k_n = k + 1'b1;
        end
      end
      // Drain lets the last butterfly of a stage reach RAM before the next stage reads.
      DRAIN: begin
        if (dcnt == CW'(DLY - 1)) begin
          if (stage < N_LOG2'(N_LOG2 - 1)) begin
            state_n = RUN;
            stage_n = stage + 1'b1;
            bank_n  = ~bank_sel;
            k_n     = '0;
          end else begin
            state_n = DONE;
          end
        end else begin
          dcnt_n = dcnt + 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Addresses are computed from next-state values so the outputs are pure flops.
  always_comb begin
    kx   = {1'b0, k_n};
    half = N_LOG2'(1) << stage_n;
    mask = half - 1'b1;
    a_n  = ((kx & ~mask) << 1) | (kx & mask);
    b_n  = a_n + half;
    tw_n = (k_n & mask[KW-1:0]) << (N_LOG2'(N_LOG2 - 1) - stage_n);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      k           <= '0;
      dcnt        <= '0;
      stage       <= '0;
      bank_sel    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      in_valid    <= 1'b0;
      rd_addrA    <= '0;
      rd_addrB    <= '0;
      twiddle_idx <= '0;
    end else begin
      state       <= state_n;
      k           <= k_n;
      dcnt        <= dcnt_n;
      stage       <= stage_n;
      bank_sel    <= bank_n;
      busy        <= (state_n == RUN) || (state_n == DRAIN);
      done        <= (state_n == DONE);
      in_valid    <= (state_n == RUN);
      rd_addrA    <= a_n;
      rd_addrB    <= b_n;
      twiddle_idx <= tw_n;
    end
  end

  logic [WW-1:0] wr_bus;

  fft_delay_line #(.DEPTH(DLY), .WIDTH(WW)) u_wr_dly (
    .clk  (clk),
    .rst  (rst),
    .din  ({in_valid, rd_addrA, rd_addrB, bank_sel}),
    .dout (wr_bus)
  );

  assign {wr_en, wr_addrA, wr_addrB, wr_bank_sel} = wr_bus;
endmodule

// File: doc/fft_agu.md
FFT_AGU -- requirements
Module: fft_agu

Interface
REQ-001 SHALL have parameter N_LOG2, default fft_consts::N_LOG2 (10), meaning log2 of the FFT length.
REQ-002 SHALL have parameter RD_LAT, default fft_consts::RAM_RD_LAT (1), meaning RAM read latency in cycles.
REQ-003 SHALL have parameter BFU_LAT, default fft_consts::BFU_LAT (5), meaning BFU pipeline latency in cycles.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  request an FFT; sampled only in IDLE.
REQ-007 busy  out  1  high while an FFT is in progress.
REQ-008 done  out  1  one-cycle completion pulse.
REQ-009 stage  out  N_LOG2  current stage index, 0..N_LOG2-1.
REQ-010 rd_addrA / rd_addrB  out  N_LOG2 each  butterfly input read addresses.
REQ-011 twiddle_idx  out  N_LOG2-1  twiddle ROM index.
REQ-012 in_valid  out  1  read addresses and twiddle_idx valid this cycle.
REQ-013 bank_sel  out  1  read-side bank: 0 = read RAM A and write RAM B; 1 = the reverse.
REQ-014 wr_addrA / wr_addrB  out  N_LOG2 each  butterfly output write addresses.
REQ-015 wr_en  out  1  write strobe aligned with BFU output.
REQ-016 wr_bank_sel  out  1  bank_sel aligned with wr_en.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-018 IDLE -> RUN when start=1; stage, k and bank_sel are cleared on entry.
REQ-019 RUN SHALL last N/2 = 512 cycles, with in_valid=1 and butterfly counter k = 0..511, one butterfly per cycle.
REQ-020 Per stage s: half = 1<<s, j = k>>s, p = k & (half-1).
REQ-021 Address rules: rd_addrA = (j<<(s+1)) | p; rd_addrB = rd_addrA + half; twiddle_idx = p << (N_LOG2-1-s); all unsigned, truncated to port width.
REQ-022 RUN -> DRAIN after k=511; DRAIN SHALL last RD_LAT+BFU_LAT cycles with in_valid=0.
REQ-023 DRAIN -> RUN with stage+1 and bank_sel toggled when stage < N_LOG2-1; otherwise DRAIN -> DONE.
REQ-024 DONE SHALL last one cycle with done=1, then go to IDLE; start is ignored in DONE.
REQ-025 busy SHALL be 1 in RUN and DRAIN and 0 in IDLE and DONE; start while busy has no effect.
REQ-026 wr_en, wr_addrA, wr_addrB and wr_bank_sel SHALL equal in_valid, rd_addrA, rd_addrB and bank_sel delayed exactly RD_LAT+BFU_LAT cycles (6 cycles at defaults).
REQ-027 The last write of a stage SHALL land in the final DRAIN cycle, so no read of stage s+1 precedes a write of stage s.
REQ-028 Timing at defaults, with start sampled at cycle 0: busy covers cycles 1..5180 (10 x 518); done=1 at cycle 5181.
REQ-029 Final results SHALL be in RAM A, because stage 9 runs with bank_sel=1.
REQ-030 All outputs SHALL be registered; rd_* and wr_* outputs have no combinational path from start.

Reset
REQ-031 Asserting rst SHALL force, asynchronously, state=IDLE and all outputs to 0 (busy, done, stage, addresses, twiddle_idx, in_valid, bank_sel, wr_*), and clear the delay line.
REQ-032 Reset asserted mid-operation SHALL discard all pending writes; no wr_en may occur after rst deasserts until a new start.
REQ-033 After rst deasserts, the block SHALL sit in IDLE until start.

Structure
REQ-034 Package fft_consts SHALL gain the constant RAM_RD_LAT=1 and the typedef agu_state_t (IDLE, RUN, DRAIN, DONE); the existing N_LOG2 and BFU_LAT are reused.
REQ-035 There SHALL be one sub-module, fft_delay_line: a parameterised depth x width register shift chain with async reset, used for the wr_* alignment.
REQ-036 Port names and directions SHALL match the agu_if fsm modport; the wr_* ports are additions.

Verification
REQ-037 Reset: hold rst with random start -> every output = 0, and wr_en stays 0 for 20 cycles after release.
REQ-038 Start: start=1 at cycle 0 -> at cycle 1 in_valid=1, stage=0, A=0, B=1, twiddle_idx=0; at cycle 2 A=2, B=3; at cycle 7 wr_en=1, wr_addrA=0, wr_addrB=1, wr_bank_sel=0.
REQ-039 Address math: stage 3, k=9 -> A=17, B=25, twiddle_idx=64; stage 9, k=5 -> A=5, B=517, twiddle_idx=5, bank_sel=1.
REQ-040 Full run: done=1 at exactly cycle 5181; 5120 wr_en pulses; each address 0..1023 written exactly once per stage; bank_sel toggles 9 times.
REQ-041 Busy and done: start pulsed at cycle 3000 and in the DONE cycle -> ignored (no restart); start at cycle 5183 -> new run begins at cycle 5184.
REQ-042 Abort: rst pulsed at cycle 2500 (stage 4) -> outputs 0 the same cycle, no stale wr_en afterwards; a following start gives the REQ-038 sequence.
